// File: rtl/iadc_ctrl_pkg.sv
// Shared types and defaults for the incremental-ADC conversion controller.
package iadc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESET   = 2'd1,
        CONVERT = 2'd2
    } conv_state_t;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_OSR    = 512;

endpackage

// File: rtl/iadc_conv_ctrl.sv
// Conversion sequencer for the sinc decimation filter: holds the filter in
// reset between conversions, waits for its new_data strobe, captures the
// result and offers it downstream on a valid/ready handshake.
module iadc_conv_ctrl
    import iadc_ctrl_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RST_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic              i_abort,
    input  logic              i_clr_status,
    input  logic [DATA_W-1:0] i_filt_data,
    input  logic              i_filt_new_data,
    output logic              o_filt_rst_n,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_result,
    output logic              o_result_valid,
    input  logic              i_result_ready,
    output logic              o_overrun,
    output logic              o_timeout
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    conv_state_t       r_state;
    logic [RC_W-1:0]   r_rst_cnt;
    logic [WD_W-1:0]   r_wdog;
    logic              r_filt_rst_n;
    logic              r_busy;
    logic [DATA_W-1:0] r_result;
    logic              r_result_valid;
    logic              r_overrun;
    logic              r_timeout;

    logic w_capture;
    logic w_expire;

    // Abort discards an in-flight conversion, so it also suppresses capture
    // and watchdog expiry; a strobe on the expiry cycle still captures.
    assign w_capture = (r_state == CONVERT) && i_filt_new_data && !i_abort;
    assign w_expire  = (r_state == CONVERT) && !i_filt_new_data && !i_abort &&
                       (r_wdog == WD_LAST);

    // Sequencer: state, reset/watchdog counters and registered control outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_rst_cnt    <= '0;
            r_wdog       <= '0;
            r_filt_rst_n <= 1'b0;
            r_busy       <= 1'b0;
        end else if (i_abort) begin
            r_state      <= IDLE;
            r_filt_rst_n <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_filt_rst_n <= 1'b0;
                    if (i_start) begin
                        r_state   <= RESET;
                        r_rst_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                RESET: begin
                    if (r_rst_cnt == RC_LAST) begin
                        r_state      <= CONVERT;
                        r_wdog       <= '0;
                        r_filt_rst_n <= 1'b1;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                CONVERT: begin
                    if (w_capture) begin
                        r_filt_rst_n <= 1'b0;
                        if (i_continuous) begin
                            r_state   <= RESET;
                            r_rst_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_expire) begin
                        r_state      <= IDLE;
                        r_filt_rst_n <= 1'b0;
                        r_busy       <= 1'b0;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_filt_rst_n <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    // Result holding register and downstream valid/ready handshake
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else if (w_capture) begin
            r_result       <= i_filt_data;
            r_result_valid <= 1'b1;
        end else if (r_result_valid && i_result_ready) begin
            r_result_valid <= 1'b0;
        end
    end

    // Sticky status flags; a set event on the same edge beats the clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_capture && r_result_valid && !i_result_ready) begin
                r_overrun <= 1'b1;
            end else if (i_clr_status) begin
                r_overrun <= 1'b0;
            end
            if (w_expire) begin
                r_timeout <= 1'b1;
            end else if (i_clr_status) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign o_filt_rst_n   = r_filt_rst_n;
    assign o_busy         = r_busy;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_overrun      = r_overrun;
    assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_iadc_conv_ctrl.sv
// Directed self-checking bench for iadc_conv_ctrl with a simple filter model
// that strobes new_data 512 cycles after filt_rst_n is released.
module tb_iadc_conv_ctrl;

    localparam int DATA_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              continuous;
    logic              abort;
    logic              clr_status;
    logic [DATA_W-1:0] filt_data;
    logic              filt_new_data;
    logic              filt_rst_n;
    logic              busy;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              result_ready;
    logic              overrun;
    logic              timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    iadc_conv_ctrl #(.DATA_W(DATA_W), .RST_CYCLES(2), .TIMEOUT(1024)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_continuous   (continuous),
        .i_abort        (abort),
        .i_clr_status   (clr_status),
        .i_filt_data    (filt_data),
        .i_filt_new_data(filt_new_data),
        .o_filt_rst_n   (filt_rst_n),
        .o_busy         (busy),
        .o_result       (result),
        .o_result_valid (result_valid),
        .i_result_ready (result_ready),
        .o_overrun      (overrun),
        .o_timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starting at the current negedge, count cycles with busy=1 and
    // filt_rst_n=0 until filt_rst_n is seen high (first CONVERT cycle).
    task automatic wait_rise(output int low_cnt);
        bit seen;
        low_cnt = 0;
        seen    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (filt_rst_n) begin
                seen = 1'b1;
                break;
            end
            if (busy) low_cnt++;
            @(negedge clk);
            start = 1'b0;
        end
        if (!seen) check_eq("rise_bound", 32'd0, 32'd1);
    endtask

    // Filter model: strobe so that new_data is sampled 512 edges after release.
    task automatic strobe(input logic [DATA_W-1:0] d);
        repeat (511) @(negedge clk);
        filt_data     = d;
        filt_new_data = 1'b1;
        @(negedge clk);
        filt_new_data = 1'b0;
    endtask

    int low;
    int conv_cycles;

    initial begin
        rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
        clr_status = 1'b0; filt_data = '0; filt_new_data = 1'b0; result_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_filt_rst_n", filt_rst_n, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_valid", result_valid, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_timeout", timeout, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single shot
        start = 1'b1;
        wait_rise(low);
        check_eq("ss_low_cycles", low, 2);
        strobe(12'hABC);
        check_eq("ss_result", result, 12'hABC);
        check_eq("ss_valid", result_valid, 1);
        check_eq("ss_busy", busy, 0);
        check_eq("ss_filt_rst_n", filt_rst_n, 0);
        result_ready = 1'b1;
        @(negedge clk);
        check_eq("ss_consumed", result_valid, 0);

        // Continuous, downstream always ready
        continuous = 1'b1;
        start = 1'b1;
        wait_rise(low);
        strobe(12'h100);
        check_eq("c1_result", result, 12'h100);
        check_eq("c1_valid", result_valid, 1);
        check_eq("c1_busy", busy, 1);
        wait_rise(low);
        check_eq("c2_low_cycles", low, 2);
        strobe(12'h200);
        check_eq("c2_result", result, 12'h200);
        check_eq("c2_valid", result_valid, 1);
        continuous = 1'b0;
        wait_rise(low);
        check_eq("c3_low_cycles", low, 2);
        strobe(12'h300);
        check_eq("c3_result", result, 12'h300);
        check_eq("c3_valid", result_valid, 1);
        check_eq("c3_busy", busy, 0);
        check_eq("c3_overrun", overrun, 0);
        @(negedge clk);
        result_ready = 1'b0;

        // Overrun: two captures with no reader
        continuous = 1'b1;
        start = 1'b1;
        wait_rise(low);
        strobe(12'h111);
        check_eq("ov1_result", result, 12'h111);
        check_eq("ov1_overrun", overrun, 0);
        continuous = 1'b0;
        wait_rise(low);
        strobe(12'h222);
        check_eq("ov2_result", result, 12'h222);
        check_eq("ov2_overrun", overrun, 1);
        check_eq("ov2_valid", result_valid, 1);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        check_eq("ov_cleared", overrun, 0);

        // Watchdog: filter never strobes
        start = 1'b1;
        wait_rise(low);
        conv_cycles = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!busy) break;
            if (filt_rst_n) conv_cycles++;
            @(negedge clk);
        end
        check_eq("to_cycles", conv_cycles, 1024);
        check_eq("to_flag", timeout, 1);
        check_eq("to_busy", busy, 0);
        check_eq("to_valid", result_valid, 1);
        check_eq("to_result", result, 12'h222);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        check_eq("to_cleared", timeout, 0);

        // Abort 100 cycles into CONVERT, colliding with a strobe
        start = 1'b1;
        wait_rise(low);
        repeat (99) @(negedge clk);
        abort = 1'b1;
        filt_new_data = 1'b1;
        filt_data = 12'h5A5;
        @(negedge clk);
        abort = 1'b0;
        filt_new_data = 1'b0;
        check_eq("ab_busy", busy, 0);
        check_eq("ab_filt_rst_n", filt_rst_n, 0);
        check_eq("ab_result", result, 12'h222);
        check_eq("ab_valid", result_valid, 1);
        check_eq("ab_overrun", overrun, 0);

        // Synchronous reset during CONVERT
        start = 1'b1;
        wait_rise(low);
        repeat (10) @(negedge clk);
        check_eq("mr_pre_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mr_filt_rst_n", filt_rst_n, 0);
        check_eq("mr_busy", busy, 0);
        check_eq("mr_result", result, 0);
        check_eq("mr_valid", result_valid, 0);
        check_eq("mr_overrun", overrun, 0);
        check_eq("mr_timeout", timeout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
